// File: rtl/seq_mult_ovf.sv
// Sequential shift-add multiplier with overflow detection, signed or unsigned.
// One iteration per cycle over WIDTH cycles; registered result, flag and completion pulse.
module seq_mult_ovf #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   prod;
  logic [WIDTH-1:0] mplier;

  logic            a_sign;
  logic            start_ok;
  logic            last;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   prod_next;
  logic            ovf;

  always_comb begin
    a_sign    = (SIGNED != 0) && data_operandA[WIDTH-1];
    start_ok  = ctrl_MULT && (state != RUN);
    last      = (cnt == CW'(WIDTH - 1));
    addend    = mplier[0] ? mcand : '0;
    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode.
    prod_next = ((SIGNED != 0) && last) ? (prod - addend) : (prod + addend);
    if (SIGNED != 0)
      ovf = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
    else
      ovf = |prod[PW-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      prod           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        RUN: begin
          if (cnt == CW'(WIDTH)) begin
            state          <= DONE;
            data_result    <= prod[WIDTH-1:0];
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end else begin
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: begin
          if (start_ok) begin
            state  <= RUN;
            mcand  <= {{WIDTH{a_sign}}, data_operandA};
            mplier <= data_operandB;
            prod   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
